// File: rtl/arith_unit_mc.sv
// arith_unit_mc: multi-cycle arithmetic unit (add, sub, mul, div) with
// valid/ready handshakes on both sides.
//   clk, reset_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready   : request handshake; operands captured on accept
//   A, B, ALU_FUN         : operands and op (00 add, 01 sub, 10 mul, 11 div)
//   signed_mode           : 1 = two's complement, 0 = unsigned
//   out_valid / out_ready : result handshake; result held until accepted
//   arith_out             : 2*WIDTH result ({rem, quo} for div)
//   carry_out, overflow, div_by_zero : flags, meaningful while out_valid
//   busy                  : unit is not idle
// Add/sub finish in one cycle; mul (shift-add) and div (restoring) iterate
// WIDTH cycles on operand magnitudes, with a sign fix-up on the last step.
// Optional macro ARITH_EARLY_OUT_EN: mul by zero and div of zero skip the
// iteration and complete with latency 1.
module arith_unit_mc #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [1:0]           ALU_FUN,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   arith_out,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 div_by_zero,
    output logic                 busy
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] FUN_ADD = 2'b00;
    localparam logic [1:0] FUN_SUB = 2'b01;
    localparam logic [1:0] FUN_MUL = 2'b10;
    localparam logic [1:0] FUN_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Captured operation context
    logic             op_is_div;
    logic             neg_q;      // negate product / quotient
    logic             neg_r;      // negate remainder
    logic             div_ovf;    // signed MIN / -1
    logic [CW-1:0]    cnt;

    // Iteration registers
    logic [W2-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;

    // Next values of registered outputs
    logic             in_ready_d, out_valid_d, busy_d;
    logic [W2-1:0]    res_d;
    logic             cy_d, ov_d, dz_d;

    function automatic logic [W2-1:0] extend(input logic [WIDTH-1:0] r, input logic s);
        return {{WIDTH{s & r[WIDTH-1]}}, r};
    endfunction

    // Capture-side decode
    logic             accept;
    logic             b_zero;
    logic             early_zero;
    logic             fast_path;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   sum_w, dif_w;

    assign accept = in_valid && in_ready;
    assign b_zero = (B == '0);
    assign a_neg  = signed_mode && A[WIDTH-1];
    assign b_neg  = signed_mode && B[WIDTH-1];
    assign abs_a  = a_neg ? (WIDTH'(0) - A) : A;
    assign abs_b  = b_neg ? (WIDTH'(0) - B) : B;
    assign sum_w  = {1'b0, A} + {1'b0, B};
    assign dif_w  = {1'b0, A} - {1'b0, B};

`ifdef ARITH_EARLY_OUT_EN
    logic a_zero;
    assign a_zero     = (A == '0);
    assign early_zero = ((ALU_FUN == FUN_MUL) && (a_zero || b_zero)) ||
                        ((ALU_FUN == FUN_DIV) && a_zero && !b_zero);
`else
    assign early_zero = 1'b0;
`endif

    assign fast_path = !ALU_FUN[1] || ((ALU_FUN == FUN_DIV) && b_zero) || early_zero;

    // One iteration step of each algorithm
    logic [W2-1:0]    mul_acc_n;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic [WIDTH-1:0] rem_fix, quo_fix;
    logic             cnt_last;

    assign mul_acc_n = acc + (mplier[0] ? mcand : W2'(0));
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, dvs});
    // Remainder always stays below the divisor, so WIDTH-bit modular subtract is exact
    assign rem_n     = div_ge ? (div_shift[WIDTH-1:0] - dvs) : div_shift[WIDTH-1:0];
    assign quo_n     = {quo[WIDTH-2:0], div_ge};
    assign rem_fix   = neg_r ? (WIDTH'(0) - rem_n) : rem_n;
    assign quo_fix   = neg_q ? (WIDTH'(0) - quo_n) : quo_n;
    assign cnt_last  = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = fast_path ? DONE : CALC;
            CALC:    if (cnt_last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        in_ready_d  = (state_next == IDLE);
        out_valid_d = (state_next == DONE);
        busy_d      = (state_next != IDLE);
        res_d       = arith_out;
        cy_d        = carry_out;
        ov_d        = overflow;
        dz_d        = div_by_zero;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    // Multi-cycle and early-out ops start from a zero result
                    res_d = '0;
                    cy_d  = 1'b0;
                    ov_d  = 1'b0;
                    dz_d  = 1'b0;
                    unique case (ALU_FUN)
                        FUN_ADD: begin
                            res_d = extend(sum_w[WIDTH-1:0], signed_mode);
                            cy_d  = sum_w[WIDTH];
                            ov_d  = signed_mode && (A[WIDTH-1] == B[WIDTH-1]) &&
                                    (sum_w[WIDTH-1] != A[WIDTH-1]);
                        end
                        FUN_SUB: begin
                            res_d = extend(dif_w[WIDTH-1:0], signed_mode);
                            cy_d  = dif_w[WIDTH];
                            ov_d  = signed_mode && (A[WIDTH-1] != B[WIDTH-1]) &&
                                    (dif_w[WIDTH-1] != A[WIDTH-1]);
                        end
                        FUN_DIV: begin
                            if (b_zero) begin
                                res_d = {A, {WIDTH{1'b1}}};
                                dz_d  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (cnt_last) begin
                    if (op_is_div) begin
                        res_d = {rem_fix, quo_fix};
                        ov_d  = div_ovf;
                    end else begin
                        res_d = neg_q ? (W2'(0) - mul_acc_n) : mul_acc_n;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    res_d = '0;
                    cy_d  = 1'b0;
                    ov_d  = 1'b0;
                    dz_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            arith_out   <= '0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            busy        <= busy_d;
            arith_out   <= res_d;
            carry_out   <= cy_d;
            overflow    <= ov_d;
            div_by_zero <= dz_d;
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_is_div <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_ovf   <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                op_is_div <= (ALU_FUN == FUN_DIV);
                neg_q     <= a_neg ^ b_neg;
                neg_r     <= a_neg;
                div_ovf   <= signed_mode && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
                cnt       <= '0;
                mcand     <= {WIDTH'(0), abs_a};
                mplier    <= abs_b;
                acc       <= '0;
                rem       <= '0;
                quo       <= abs_a;
                dvs       <= abs_b;
            end
        end else if (state == CALC) begin
            cnt    <= cnt + CW'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= mul_acc_n;
            rem    <= rem_n;
            quo    <= quo_n;
        end
    end

endmodule

// File: doc/arith_unit_mc.md
Name: arith_unit_mc

Overview:
Multi-cycle, parametrised successor to the single-cycle ARITH_UNIT of the hierarchical ALU.
- Add/sub in one cycle; multiply (shift-add) and divide (restoring) iterate over WIDTH cycles instead of inferring wide combinational `*` and `/`.
- Selectable signed/unsigned mode, valid/ready handshake on both sides, and explicit carry, overflow and divide-by-zero flags.
- Sits under the ALU top-level decoder in place of ARITH_UNIT.

Parameters:
WIDTH, 16, operand width in bits (≥4); result is 2*WIDTH.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
A  input  WIDTH  operand A / dividend
B  input  WIDTH  operand B / divisor
ALU_FUN  input  2  00 add, 01 sub, 10 mul, 11 div
signed_mode  input  1  1 = two's complement, 0 = unsigned
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
arith_out  output  2*WIDTH  result
carry_out  output  1  add carry / sub borrow (unsigned view)
overflow  output  1  signed add/sub overflow, or div MIN/-1
div_by_zero  output  1  div with B==0
busy  output  1  state != IDLE

Behaviour:
- Reset: async, active-low. State goes to IDLE. All outputs go to 0 except in_ready, which is 1. Reset mid-calculation aborts the calculation with no output.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture A, B, ALU_FUN and signed_mode. Inputs are ignored after capture.
  - Next state: DONE for add/sub/div-by-zero; CALC for mul/div.
- CALC:
  - in_ready=0.
  - An iteration counter ($clog2(WIDTH+1) bits) runs exactly WIDTH cycles, then the state goes to DONE.
- DONE:
  - out_valid=1 and results are stable.
  - On out_ready, next state is IDLE and out_valid drops the next cycle.
  - in_ready=0 in DONE, so there is no overlap. Back-to-back throughput is one op per (latency+1) cycles minimum.
- Latency (accept edge to out_valid high):
  - add/sub: 1 cycle.
  - mul/div: WIDTH+1 cycles.
  - div by zero: 1 cycle.
- add/sub:
  - Result is sign-extended to 2*WIDTH when signed_mode=1, else zero-extended.
  - carry_out = bit WIDTH of the unsigned (WIDTH+1)-bit sum, or borrow (A<B unsigned) for sub.
  - overflow = signed overflow when signed_mode=1, else 0.
- mul:
  - Operate on magnitudes; negate the product if signed_mode and the signs differ.
  - arith_out = full 2*WIDTH product.
  - carry_out=0, overflow=0.
- div:
  - Restoring algorithm on magnitudes.
  - arith_out = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed MIN / -1: quotient = MIN (wrapped), remainder 0, overflow=1.
- div, B==0:
  - No iteration.
  - quotient = all ones, remainder = A, div_by_zero=1.
- Flags are valid only while out_valid=1 and are cleared on leaving DONE.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Optional Feature:
ARITH_EARLY_OUT_EN
- Defined: mul with A==0 or B==0, and div with A==0 (B≠0), skip CALC. The state goes IDLE→DONE with result 0 and latency 1.
- Undefined: these cases take the full WIDTH+1 latency with the same result.

Test Plan:
- WIDTH=16, unsigned, add 0xFFFF+0x0001 → after 1 cycle out_valid=1, arith_out=0x00000000, carry_out=1, overflow=0.
- Signed sub 0x8000-0x0001 → arith_out=0x00007FFF, overflow=1, carry_out=0.
- Signed mul -3*7 → out_valid exactly 17 cycles after accept, arith_out=0xFFFFFFEB. Unsigned mul 0xFFFF*0xFFFF → 0xFFFE0001.
- Signed div -7/2 → quotient 0xFFFD, remainder 0xFFFF. Signed div 0x8000/0xFFFF → quotient 0x8000, overflow=1. Div 0x1234/0 → 1 cycle, div_by_zero=1, arith_out=0x1234FFFF.
- Hold out_ready=0 for 5 cycles in DONE → out_valid and arith_out stable, in_ready=0, a new in_valid is ignored. Release out_ready → IDLE next cycle.
- Assert reset_n=0 at cycle 8 of a mul → all outputs 0 and in_ready=1 immediately. A following add 2+3 returns 5 normally.
